// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB requester.
// Latency: none, declarations only.
// Backpressure: not applicable.
package definesPkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apbState_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the cycle on which the limit is hit.
// Latency: expire is combinational on inc during the final allowed wait cycle.
// Backpressure: none; clr restarts the count, inc advances it.
// Built only when APB_TIMEOUT_EN is defined.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic pclk,
  input  logic rstN,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear on SETUP so every ACCESS phase starts from zero, count waits otherwise.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // The last wait cycle allowed is the one that would bring the count to the limit.
  always_comb begin
    expire = inc && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Counter register.
  always_ff @(posedge pclk or negedge rstN) begin
    if (!rstN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: turns single valid/ready commands into SETUP/ACCESS transfers.
// Latency: accept at edge N -> SETUP N+1, ACCESS N+2, rspValid N+3 plus one per wait state.
// Backpressure: cmdReady only in IDLE or on the completing ACCESS cycle; response has none.
// Optional: APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait states.
module apb_master
  import definesPkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  rstN,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic                  cmdWrite,
  input  logic [ADDR_WIDTH-1:0] cmdAddr,
  input  logic [DATA_WIDTH-1:0] cmdWdata,
  output logic                  rspValid,
  output logic [DATA_WIDTH-1:0] rspRdata,
  output logic                  rspErr,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apbState_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic accept;
  logic done;
  logic timeout_hit;

  assign done     = (state_q == ACCESS) && pready;
  assign cmdReady = (state_q == IDLE) || done;
  assign accept   = cmdValid && cmdReady;

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .pclk   (pclk),
    .rstN   (rstN),
    .clr    (state_q == SETUP),
    .inc    ((state_q == ACCESS) && !pready),
    .expire (timeout_hit)
  );
`else
  // Without the timer ACCESS waits for pready forever.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
`endif

  // State register; reset drops psel/penable immediately and abandons any transfer.
  always_ff @(posedge pclk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a completing ACCESS may chain straight into SETUP if a command is waiting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (done) begin
          state_d = accept ? SETUP : IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus control outputs decoded from state.
  always_comb begin
    psel    = (state_q != IDLE);
    penable = (state_q == ACCESS);
  end

  // Command capture and response generation; write data only moves on write accepts.
  always_comb begin
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      paddr_d  = cmdAddr;
      pwrite_d = cmdWrite;
      if (cmdWrite) begin
        pwdata_d = cmdWdata;
      end
    end
    if (done) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = pwrite_q ? '0 : prdata;
      rsp_err_d   = pslverr;
    end else if (timeout_hit) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end
  end

  // Datapath and response registers.
  always_ff @(posedge pclk or negedge rstN) begin
    if (!rstN) begin
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign paddr    = paddr_q;
  assign pwrite   = pwrite_q;
  assign pwdata   = pwdata_q;
  assign rspValid = rsp_valid_q;
  assign rspRdata = rsp_rdata_q;
  assign rspErr   = rsp_err_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Synthesizable APB (AMBA3) requester: drives the requester end of the same APB bus that apb_slave responds on, so the bus can be driven by RTL rather than only by the bench BFM tasks.
- Accepts single read/write commands on a valid/ready command port and runs the APB SETUP/ACCESS sequence.
- Returns read data and error status on a one-cycle response pulse.
- Sits between an internal control engine and any APB-attached register block such as apb_slave.

Parameters:
- ADDR_WIDTH, 8: width of cmdAddr and paddr.
- DATA_WIDTH, 32: width of write/read data buses.
- TIMEOUT_CYCLES, 16: maximum wait-state cycles in ACCESS before abort; used only with APB_TIMEOUT_EN.

Ports:
- pclk  input  1  APB clock; all state changes on its rising edge.
- rstN  input  1  asynchronous, active-low reset.
- cmdValid  input  1  command present.
- cmdReady  output  1  command accepted when cmdValid && cmdReady at a rising edge.
- cmdWrite  input  1  1 = write, 0 = read.
- cmdAddr  input  ADDR_WIDTH  transfer address.
- cmdWdata  input  DATA_WIDTH  write data.
- rspValid  output  1  one-cycle pulse: transfer complete.
- rspRdata  output  DATA_WIDTH  read data; 0 for writes.
- rspErr  output  1  pslverr sampled at completion, or timeout.
- paddr  output  ADDR_WIDTH  APB address.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- pwdata  output  DATA_WIDTH  APB write data.
- prdata  input  DATA_WIDTH  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB slave error.

Behaviour:
- Clock and reset: one clock, pclk. Reset rstN is asynchronous and active-low.
- Reset values: state IDLE; psel, penable, pwrite, rspValid, rspErr = 0; paddr, pwdata, rspRdata = 0.
- State machine apbState_t has three states: IDLE, SETUP, ACCESS.
  - IDLE: psel=0, penable=0. On accept, go to SETUP.
  - SETUP: lasts exactly one cycle. psel=1, penable=0; paddr, pwrite, pwdata loaded from the accepted command. Then go to ACCESS.
  - ACCESS: psel=1, penable=1. Stay while pready=0 (wait states).
  - ACCESS completion, on a pready=1 edge: if a new command is accepted on the same edge, go to SETUP (back-to-back, psel stays 1, penable drops). Otherwise go to IDLE.
- cmdReady = (state==IDLE) || (state==ACCESS && pready). This is combinational on pready; cmdReady is never 1 in SETUP.
- Hold rules:
  - paddr, pwrite and pwdata are registered and stable from SETUP through ACCESS completion.
  - In IDLE they keep their last values.
  - pwdata updates only on write accepts.
- Latency for an accept at edge N:
  - SETUP is cycle N+1; ACCESS starts at cycle N+2.
  - Zero-wait completion at the end of N+2, so rspValid=1 in cycle N+3.
  - Each wait state adds one cycle.
- Response:
  - rspValid is a registered pulse exactly one cycle long, with no backpressure.
  - rspRdata captures prdata on a read completion; it is set to 0 on a write completion.
  - rspErr = pslverr at the completion edge.
  - rspRdata and rspErr hold their values until the next completion.
- Back-to-back transfers: sustained throughput is one transfer per 2 cycles at zero wait states. No IDLE cycle is inserted between transfers.
- cmdValid while not ready: the command is ignored. Command inputs need be stable only at the accepting edge.
- Reset mid-transfer: psel and penable drop immediately (asynchronous), state goes to IDLE, and no rspValid is generated for the aborted transfer.
- pslverr is ignored outside the ACCESS completion edge.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYCLES, the block drops psel and penable, returns to IDLE, and pulses rspValid with rspErr=1 and rspRdata=0.
  - No back-to-back accept occurs on a timeout edge.
  - pready=1 on the same edge as the counter hitting TIMEOUT_CYCLES is a normal completion; the timeout is not taken.
- Undefined: ACCESS waits indefinitely for pready, and the counter logic is absent.

Decomposition:
- definesPkg gets:
  - typedef enum apbState_t {IDLE, SETUP, ACCESS};
  - default width constants APB_ADDR_W=8 and APB_DATA_W=32.
- Optional sub-module apb_wait_timer (counter plus terminal-count flag), instantiated only under APB_TIMEOUT_EN.
- The main FSM and datapath stay in apb_master.

Test Plan:
- Write 0x32←0x10 with pready tied 1:
  - psel=1 at N+1, penable=1 at N+2, rspValid at N+3, rspErr=0.
  - pwdata=0x10 and paddr=0x32 stable over both cycles.
- Read 0x32 with the slave inserting 3 wait states:
  - penable stays high 4 cycles; rspValid pulses once with rspRdata=0x10 (written earlier).
- cmdValid held with write 0x36←0x14 followed by read 0x36:
  - psel never drops between the transfers; second SETUP immediately follows first completion.
  - Two rspValid pulses 2 cycles apart; second rspRdata=0x14.
- Slave asserts pslverr on a write to 0x3A: rspErr=1 for that response only; the next clean read gives rspErr=0.
- rstN pulled low mid-ACCESS: psel and penable go 0 within the same cycle, with no rspValid; after release a new write completes normally.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0:
  - rspValid with rspErr=1 and rspRdata=0 after 16 wait cycles; psel low the cycle after.
